// File: rtl/muldiv_alu_control.sv
// -----------------------------------------------------------------------------
// muldiv_alu_control
//
// ALU control decoder with an attached iterative multiply/divide unit.
//
// The alu_cnt select is decoded combinationally from the main-decoder op class
// (alu_op) and the R-type function field (funct). When the decode selects the
// mul/div class (1110) and start is high in IDLE, the operation is accepted:
//   - mult/multu: one shift-add step per cycle.
//   - div/divu:   one restoring-subtract step per cycle.
// Each of these runs WIDTH steps, with busy high for exactly WIDTH cycles.
// Signed operations work on magnitudes. The sign is fixed up on the edge that
// enters DONE, which is also the only edge that updates hi/lo.
// A divide by zero skips RUN and goes straight to DONE with div_by_zero set.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        operation request (acted on only in IDLE with alu_cnt=1110)
//   alu_op[2:0]  main-decoder op class
//   funct[5:0]   R-type function field
//   a, b         rs / rt operands (latched on the accepting edge)
//   alu_cnt      ALU select (combinational)
//   busy         high while the iterative op runs
//   done         one-cycle completion pulse
//   hi, lo       result registers (remainder/quotient or product halves)
//   div_by_zero  divide-by-zero flag, valid only while done=1
// -----------------------------------------------------------------------------
module muldiv_alu_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] alu_cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [AW-1:0]           acc;       // {partial/remainder (WIDTH+1), low word}
  logic [WIDTH-1:0]        opnd;      // |b|: multiplicand or divisor
  logic                    is_div;
  logic                    neg_lo;    // negate product (mult) or quotient (div)
  logic                    neg_hi;    // negate remainder (div)

  // ---------------------------------------------------------------------------
  // ALU select decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_cnt = CNT_W'(4'b1111);
    case (alu_op)
      3'b000: alu_cnt = CNT_W'(4'b0010);
      3'b001: alu_cnt = CNT_W'(4'b0110);
      3'b011: alu_cnt = CNT_W'(4'b0000);
      3'b100: alu_cnt = CNT_W'(4'b0001);
      3'b101: alu_cnt = CNT_W'(4'b0111);
      3'b010: begin
        case (funct)
          6'b100000, 6'b100001: alu_cnt = CNT_W'(4'b0010);
          6'b100010, 6'b100011: alu_cnt = CNT_W'(4'b0110);
          6'b100100:            alu_cnt = CNT_W'(4'b0000);
          6'b100101:            alu_cnt = CNT_W'(4'b0001);
          6'b100111:            alu_cnt = CNT_W'(4'b1100);
          6'b101010, 6'b101011: alu_cnt = CNT_W'(4'b0111);
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: alu_cnt = CNT_W'(4'b1110);
          default:              alu_cnt = CNT_W'(4'b1111);
        endcase
      end
      default: alu_cnt = CNT_W'(4'b1111);
    endcase
  end

  logic muldiv_sel;
  assign muldiv_sel = (alu_cnt == CNT_W'(4'b1110));

  // ---------------------------------------------------------------------------
  // Operand magnitudes at acceptance (funct[0]=0 selects the signed variants)
  // ---------------------------------------------------------------------------
  logic             sa, sb;
  logic [WIDTH-1:0] amag, bmag;

  always_comb begin
    sa   = ~funct[0] & a[WIDTH-1];
    sb   = ~funct[0] & b[WIDTH-1];
    amag = sa ? -a : a;
    bmag = sb ? -b : b;
  end

  // ---------------------------------------------------------------------------
  // One iteration step and the sign-corrected final results
  // ---------------------------------------------------------------------------
  logic [AW-1:0]        acc_step, shl;
  logic [WIDTH:0]       sum, rem_sh, trial;
  logic [2*WIDTH-1:0]   pmag, prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    trial    = '0;
    shl      = '0;
    acc_step = acc;
    if (is_div) begin
      // Restoring divide: shift the dividend bit into the remainder, and keep
      // the trial difference only when it does not go negative.
      shl    = acc << 1;
      rem_sh = shl[AW-1:WIDTH];
      trial  = rem_sh - {1'b0, opnd};
      if (rem_sh >= {1'b0, opnd}) acc_step = {trial, shl[WIDTH-1:1], 1'b1};
      else                        acc_step = shl;
    end else begin
      // Shift-add multiply: the carry lands in the extra top bit.
      sum      = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      acc_step = {sum, acc[WIDTH-1:0]} >> 1;
    end

    pmag = acc_step[2*WIDTH-1:0];
    prod = neg_lo ? -pmag : pmag;
    quo  = neg_lo ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
    rem  = neg_hi ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: every register here, the wide accumulator included, is cleared by
  // the async reset so an aborted op leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && muldiv_sel) begin
            is_div <= funct[1];
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            opnd   <= bmag;
            acc    <= {{(WIDTH+1){1'b0}}, amag};
            cnt    <= '0;
            if (funct[1] && (b == '0)) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              hi          <= a;
              lo          <= '1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div) begin
              hi <= rem;
              lo <= quo;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
